match_scorekeeper: RTL
======================

Name: match_scorekeeper

Overview:
Downstream consumer of the round-winner detector in the tug-of-war design. It watches the per-round win indications and keeps a running score for each player. It shows both scores on two 7-segment displays. Between rounds it issues a one-cycle round_reset that clears the playfield and winner logic, and it declares the match over when either player reaches MATCH_WINS.

Parameters:
MATCH_WINS, 3, round wins needed to take the match; legal range 1..9.
HOLD_CYCLES, 4, cycles the round result is held before round_reset fires; legal range >= 1.

Ports:
clk  input  1  system clock
Reset  input  1  synchronous, active-high reset; clock clk
left_won  input  1  level, high while the current round is won by the left player
right_won  input  1  level, high while the current round is won by the right player
round_reset  output  1  one-cycle pulse that clears the playfield and winner logic for the next round
match_over  output  1  high once a player has MATCH_WINS wins; held until Reset
HEXL  output  7  left score, active-low segments {g,f,e,d,c,b,a}
HEXR  output  7  right score, same encoding

Behaviour:
- Reset values:
  - state PLAY; score_l = score_r = 0; prev_l = prev_r = 0; hold counter 0.
  - round_reset = 0, match_over = 0.
  - HEXL = HEXR = 7'b1000000 (digit 0).
- Reset wins over every other condition in every state, including mid-CELEBRATE and MATCH_OVER.
- Edge detect:
  - prev_l/prev_r register left_won/right_won every cycle in all states.
  - win_l_rise = left_won & ~prev_l; win_r_rise likewise.
  - A level held high across many cycles counts at most once.
- Scores: 4-bit unsigned, saturate at MATCH_WINS, never wrap.
- FSM states: PLAY, CELEBRATE, RESTART, MATCH_OVER.
- PLAY:
  - win_l_rise & ~win_r_rise -> score_l+1 at the same edge; load hold = HOLD_CYCLES-1; go to CELEBRATE.
  - win_r_rise & ~win_l_rise -> score_r+1, same handling.
  - Both rise in the same cycle -> tie: no score change; load hold; go to CELEBRATE; the round is replayed.
  - Neither rises -> stay in PLAY.
- CELEBRATE:
  - The winner's input is ignored.
  - hold decrements each cycle; when hold == 0:
    - either score == MATCH_WINS -> MATCH_OVER;
    - otherwise -> RESTART.
  - Occupies exactly HOLD_CYCLES cycles.
- RESTART: round_reset = 1 for exactly this one cycle (Moore output, registered); next state PLAY. Win rises in this cycle are ignored.
- MATCH_OVER: match_over = 1; round_reset stays 0; scores frozen; inputs ignored; exits only on Reset.
- Latency: the win rise is sampled at edge k, and the score is visible on HEX from edge k.
  - round_reset is high from edge k+HOLD_CYCLES to edge k+HOLD_CYCLES+1.
  - PLAY resumes at edge k+HOLD_CYCLES+1.
- Protocol assumption: the winner detector clears its level on the round_reset edge. If a level is still high in PLAY, no double count occurs because of the edge detect.
- Display: combinational decode of each score.
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other value = 1111111 (blank).

Decomposition:
- Package tug_pkg:
  - state enum (PLAY, CELEBRATE, RESTART, MATCH_OVER);
  - SEG_OFF = 7'b1111111;
  - SEG_DIGIT[0:9] constant array with the encodings above.
- Sub-module seg7_digit: 4-bit value to 7-bit active-low pattern, purely combinational, instantiated twice (HEXL, HEXR).
- FSM, counters and edge detect stay in match_scorekeeper.

Test Plan (HOLD_CYCLES=4, MATCH_WINS=3):
1. Reset held 2 cycles, then released with inputs low -> HEXL = HEXR = 1000000; round_reset = 0; match_over = 0 for 10 cycles.
2. left_won rises at edge k and stays high 8 cycles:
   - HEXL = 1111001 from k; score counts once;
   - round_reset high only for cycle k+4..k+5;
   - HEXR stays 1000000.
3. left_won and right_won rise in the same cycle -> both HEX unchanged; round_reset pulses once, 4 cycles later.
4. Right player wins three rounds (each won level dropped after round_reset):
   - HEXR shows 1111001, then 0100100, then 0110000;
   - after the third win, match_over = 1 at k+4 and no round_reset;
   - further left_won pulses are ignored.
5. Reset asserted 2 cycles into CELEBRATE with score_l = 1 -> next edge: scores 0, state PLAY, no round_reset pulse afterwards.
6. right_won rises during RESTART, then stays high -> no increment, and no increment in the following PLAY cycles until it falls and rises again.

Source files
------------

// File: rtl/match_scorekeeper_pkg.sv
// Shared types and constants for the tug-of-war match scorekeeper.
//   state_t   : scorekeeper FSM states
//   SEG_OFF   : blank pattern for an active-low 7-segment display {g,f,e,d,c,b,a}
//   SEG_DIGIT : active-low segment patterns for decimal digits 0..9
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY,
    CELEBRATE,
    RESTART,
    MATCH_OVER
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/match_scorekeeper_if.sv
// Signal bundle between the round-winner detector side and the scorekeeper.
//   left_won, right_won : per-round win levels (detector -> scorekeeper)
//   round_reset         : one-cycle playfield/winner clear pulse
//   match_over          : match finished flag, held until Reset
//   HEXL, HEXR          : active-low 7-segment score displays
// master = detector/display side, slave = scorekeeper.
interface match_scorekeeper_if;
  logic       left_won;
  logic       right_won;
  logic       round_reset;
  logic       match_over;
  logic [6:0] HEXL;
  logic [6:0] HEXR;

  modport master (
    output left_won, right_won,
    input  round_reset, match_over, HEXL, HEXR
  );

  modport slave (
    input  left_won, right_won,
    output round_reset, match_over, HEXL, HEXR
  );
endinterface

// File: rtl/match_scorekeeper_seg7.sv
// Combinational decimal digit to active-low 7-segment decoder.
//   value : 4-bit unsigned value
//   seg   : {g,f,e,d,c,b,a}, active low; blank for values above 9
module seg7_digit
  import tug_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (value <= 4'd9) seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/match_scorekeeper.sv
// Match scorekeeper: counts round wins per player from the winner levels,
// holds each round result for HOLD_CYCLES, then pulses round_reset, and
// declares the match over once a player reaches MATCH_WINS.
//   clk   : system clock
//   Reset : synchronous, active-high reset
//   bus   : slave side of match_scorekeeper_if (win levels in; round_reset,
//           match_over, HEXL/HEXR out)
module match_scorekeeper
  import tug_pkg::*;
#(
  parameter int unsigned MATCH_WINS  = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 Reset,
  match_scorekeeper_if.slave   bus
);

  localparam int unsigned    HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]     WIN_MAX   = 4'(MATCH_WINS);

  state_t        state, state_nx;
  logic [3:0]    score_l, score_r, score_l_nx, score_r_nx;
  logic [HW-1:0] hold, hold_nx;
  logic          prev_l, prev_r;
  logic          win_l_rise, win_r_rise;

  // Edge detect: a level held across many cycles counts once.
  assign win_l_rise = bus.left_won  & ~prev_l;
  assign win_r_rise = bus.right_won & ~prev_r;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= PLAY;
      score_l <= '0;
      score_r <= '0;
      hold    <= '0;
      prev_l  <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      score_l <= score_l_nx;
      score_r <= score_r_nx;
      hold    <= hold_nx;
      prev_l  <= bus.left_won;
      prev_r  <= bus.right_won;
    end
  end

  always_comb begin
    state_nx   = state;
    score_l_nx = score_l;
    score_r_nx = score_r;
    hold_nx    = hold;
    case (state)
      PLAY: begin
        if (win_l_rise || win_r_rise) begin
          // A simultaneous rise is a tie: no score, round is replayed.
          hold_nx  = HOLD_LOAD;
          state_nx = CELEBRATE;
          if (win_l_rise && !win_r_rise && score_l < WIN_MAX) score_l_nx = score_l + 4'd1;
          if (win_r_rise && !win_l_rise && score_r < WIN_MAX) score_r_nx = score_r + 4'd1;
        end
      end
      CELEBRATE: begin
        if (hold == '0) begin
          state_nx = (score_l == WIN_MAX || score_r == WIN_MAX) ? MATCH_OVER : RESTART;
        end else begin
          hold_nx = hold - 1'b1;
        end
      end
      RESTART:    state_nx = PLAY;
      MATCH_OVER: state_nx = MATCH_OVER;
      default:    state_nx = PLAY;
    endcase
  end

  // Moore outputs decoded straight from the state register.
  assign bus.round_reset = (state == RESTART);
  assign bus.match_over  = (state == MATCH_OVER);

  seg7_digit u_hexl (.value(score_l), .seg(bus.HEXL));
  seg7_digit u_hexr (.value(score_r), .seg(bus.HEXR));

endmodule
